// File: rtl/mem_req_watchdog_pkg.sv
// Shared memory-bus encodings and the request watchdog state type.
package mem_req_watchdog_pkg;

   localparam logic [4:0]  UMEM_OPM_READY   = 5'h00;
   localparam logic [1:0]  UMEM_OK_READY    = 2'd0;
   localparam logic [1:0]  UMEM_OK_OK       = 2'd1;
   localparam logic [1:0]  UMEM_OK_HOLD     = 2'd2;
   localparam logic [1:0]  UMEM_OK_FAULT    = 2'd3;
   localparam logic [63:0] UV64_00          = 64'h0;
   // Bit 15 plus [11:8]=F broadcast the exception to both join clients.
   localparam logic [15:0] UMEM_EXC_TIMEOUT = 16'h8F0A;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      FAULT  = 2'd2,
      FLUSH  = 2'd3
   } wdState_t;

endpackage

// File: rtl/mem_req_watchdog.sv
// Request-timeout guard between the memory join and the L2 port; registers
// both directions and abandons/flushes requests that outlive TIMEOUT cycles.
module mem_req_watchdog
   import mem_req_watchdog_pkg::*;
#(
   parameter int unsigned TIMEOUT = 4095
) (
   input  logic         clock,
   input  logic         reset,
   input  logic [127:0] upOutData,
   input  logic [47:0]  upAddrA,
   input  logic [47:0]  upAddrB,
   input  logic [4:0]   upOpm,
   output logic [127:0] upInData,
   output logic [1:0]   upOK,
   output logic [63:0]  upBusExc,
   input  logic [127:0] dnInData,
   input  logic [1:0]   dnOK,
   input  logic [63:0]  dnBusExc,
   output logic [127:0] dnOutData,
   output logic [47:0]  dnAddrA,
   output logic [47:0]  dnAddrB,
   output logic [4:0]   dnOpm,
   output logic [15:0]  faultCount
);

   localparam logic [15:0] TIMEOUT_M1 = 16'(TIMEOUT - 1);

   wdState_t     state, nextState;
   logic [15:0]  cnt;
   logic [47:0]  excAddr;
   logic         fwd;

   logic [127:0] nUpInData, nDnOutData;
   logic [1:0]   nUpOK;
   logic [63:0]  nUpBusExc;
   logic [47:0]  nDnAddrA, nDnAddrB;
   logic [4:0]   nDnOpm;

   always_comb begin
      nextState = state;
      case (state)
         IDLE:   if (upOpm != UMEM_OPM_READY) nextState = ACTIVE;
         ACTIVE: begin
            // Completion takes priority over a timeout landing on the same cycle.
            if (upOpm == UMEM_OPM_READY && dnOK == UMEM_OK_READY) nextState = IDLE;
            else if (cnt == TIMEOUT_M1)                            nextState = FAULT;
         end
         FAULT:  if (upOpm == UMEM_OPM_READY) nextState = FLUSH;
         FLUSH:  if (dnOK == UMEM_OK_READY)   nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   // Outputs are registered from the next state so a fault shows the same
   // edge the FSM enters FAULT. Traffic only passes while both the current
   // and next state are live, which keeps FLUSH leftovers off both buses.
   always_comb begin
      fwd        = (state == IDLE || state == ACTIVE) &&
                   (nextState == IDLE || nextState == ACTIVE);
      nDnOpm     = UMEM_OPM_READY;
      nDnAddrA   = '0;
      nDnAddrB   = '0;
      nDnOutData = '0;
      nUpOK      = UMEM_OK_READY;
      nUpInData  = '0;
      nUpBusExc  = dnBusExc;
      if (fwd) begin
         nDnOpm     = upOpm;
         nDnAddrA   = upAddrA;
         nDnAddrB   = upAddrB;
         nDnOutData = upOutData;
         nUpOK      = dnOK;
         nUpInData  = dnInData;
      end else if (nextState == FAULT) begin
         nUpOK = UMEM_OK_FAULT;
         if (state != FAULT) nUpBusExc = {excAddr, UMEM_EXC_TIMEOUT};
      end else if (nextState == FLUSH) begin
         nUpOK = UMEM_OK_HOLD;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         excAddr    <= '0;
         faultCount <= '0;
         dnOpm      <= UMEM_OPM_READY;
         dnAddrA    <= '0;
         dnAddrB    <= '0;
         dnOutData  <= '0;
         upOK       <= UMEM_OK_READY;
         upInData   <= '0;
         upBusExc   <= UV64_00;
      end else begin
         state     <= nextState;
         dnOpm     <= nDnOpm;
         dnAddrA   <= nDnAddrA;
         dnAddrB   <= nDnAddrB;
         dnOutData <= nDnOutData;
         upOK      <= nUpOK;
         upInData  <= nUpInData;
         upBusExc  <= nUpBusExc;
         if (state == IDLE && nextState == ACTIVE) begin
            cnt     <= '0;
            excAddr <= upAddrA;
         end else if (state == ACTIVE) begin
            cnt <= cnt + 16'd1;
         end
         if (state == ACTIVE && nextState == FAULT && faultCount != 16'hFFFF)
            faultCount <= faultCount + 16'd1;
      end
   end

endmodule

// File: doc/mem_req_watchdog.md
# mem_req_watchdog

Request-timeout guard placed directly downstream of the two-requester memory join and upstream of the L2/memory port. It forwards the joined request (Opm, addresses, store data) to memory and returns responses (OK, load data, bus exception) to the join, with one register stage in each direction. If a request stays outstanding longer than `TIMEOUT` cycles, the guard abandons it toward memory. It then returns FAULT plus a synthesized bus exception to the requester and drains the memory side before accepting new work.

## Interface
Parameters:
- `TIMEOUT`, default 4095: cycles an outstanding request may last before fault; legal range 2..65535.

Ports (reset is synchronous, active-high; the clock is `clock`):
- `clock`  in  1  system clock
- `reset`  in  1  synchronous, active-high reset
- `upOutData`  in  128  store data from join
- `upAddrA`  in  48  primary address from join
- `upAddrB`  in  48  secondary address from join
- `upOpm`  in  5  request op from join; 0 = READY (idle)
- `upInData`  out  128  load data to join
- `upOK`  out  2  response to join
- `upBusExc`  out  64  bus exception to join
- `dnInData`  in  128  load data from memory
- `dnOK`  in  2  memory response
- `dnBusExc`  in  64  memory bus exception
- `dnOutData`  out  128  store data to memory
- `dnAddrA`  out  48  primary address to memory
- `dnAddrB`  out  48  secondary address to memory
- `dnOpm`  out  5  request op to memory
- `faultCount`  out  16  saturating count of timeouts since reset

## Operation
- OK encoding: 0 READY, 1 OK, 2 HOLD, 3 FAULT.
- FSM states: IDLE, ACTIVE, FAULT, FLUSH. Reset enters IDLE.
- IDLE:
  - Request fields are forwarded; responses are forwarded.
  - When `upOpm` != 0: go to ACTIVE, clear the counter, and latch `upAddrA` into `excAddr`.
- ACTIVE:
  - Forwarding continues as in IDLE; the counter increments every cycle.
  - When `upOpm` == 0 and `dnOK` == READY: go to IDLE.
  - When the counter == `TIMEOUT`-1 and the exit condition is false: go to FAULT.
  - If both conditions are true in the same cycle, completion wins.
- FAULT:
  - `dnOpm` is forced to 0, which abandons the request; the address and data outputs are zero.
  - `upOK` = FAULT and `upInData` = 0.
  - On the first FAULT cycle only, `upBusExc` = {`excAddr`, 16'h8F0A}. Bit 15 set and [11:8]=F broadcast the exception to both join clients. `dnBusExc` is dropped on that cycle.
  - On later FAULT cycles, `upBusExc` forwards `dnBusExc`.
  - `faultCount` increments once, saturating at 16'hFFFF.
  - When `upOpm` == 0: go to FLUSH.
- FLUSH:
  - `dnOpm` = 0 and `upOK` = HOLD. Late `dnInData` and `dnOK` are discarded and never reach the join.
  - When `dnOK` == READY: go to IDLE.
  - FLUSH has no timeout.
- Outside the first FAULT cycle, `dnBusExc` is forwarded unchanged in every state.

## Timing
- All outputs are registered.
- Latency: `up*` request inputs appear on `dn*` 1 cycle later; `dn*` response inputs appear on `up*` 1 cycle later. The round trip adds 2 cycles to the join's view.
- The counter starts at 0 on the cycle after the IDLE→ACTIVE transition. FAULT response becomes visible on `upOK` `TIMEOUT`+1 cycles after `upOpm` first goes non-zero.
- The handshake is unchanged from memory: a requester holds `upOpm` until it sees OK or FAULT, then drops it to 0.
- Reset values: every output is 0 (`upOK` = READY, `dnOpm` = READY, `faultCount` = 0). State is IDLE and the counter is 0.
- Reset mid-request: the same values apply on the next edge. Memory is not flushed, and the guard does not wait for `dnOK`.
- A new `upOpm` arriving in FLUSH is held off with HOLD and is not forwarded until IDLE.
- Back-to-back requests: a request arriving on the same cycle ACTIVE exits to IDLE starts a fresh ACTIVE on the next cycle, with the counter cleared.

## Structure
- Shared memory-bus package holds:
  - `UMEM_OPM_READY` (5'h00)
  - `UMEM_OK_READY`/`UMEM_OK_OK`/`UMEM_OK_HOLD`/`UMEM_OK_FAULT` (0..3)
  - `UV64_00`
  - new `UMEM_EXC_TIMEOUT` (16'h8F0A)
  - state enum
- Single module; the counter and FSM are inline. No sub-module is warranted.

## Test plan
- Pass-through: `upOpm`=5'h11, addr 48'h1000. Memory answers OK after 3 cycles with data 128'hA5… → `upOK`=OK 1 cycle later, `upInData` matches, `faultCount`=0, ends in IDLE.
- Timeout with `TIMEOUT`=8: memory holds HOLD indefinitely.
  - → `upOK`=FAULT 9 cycles after request.
  - → `upBusExc`=64'h0000_0000_1000_8F0A for exactly 1 cycle.
  - → `dnOpm`=0 and `faultCount`=1.
- Flush: after a fault, the requester drops `upOpm`; memory returns late OK for 2 cycles, then READY → `upOK`=HOLD throughout, no late data leaks, IDLE after READY.
- Race: completion on counter == `TIMEOUT`-1 → normal OK, no exception, `faultCount` unchanged.
- Reset mid-ACTIVE → next cycle all outputs 0, IDLE. A new request afterwards is forwarded normally.
- Memory bus-exception 64'h…8110 during ACTIVE → forwarded unchanged to `upBusExc` 1 cycle later.
